// File: rtl/intpol2_pkg.sv
// intpol2_pkg: shared mode/state encodings and width helpers for the streaming quadratic interpolator
package intpol2_pkg;
   typedef enum logic [1:0] {MODE_QUAD = 2'd0, MODE_LIN = 2'd1, MODE_ZOH = 2'd2, MODE_QUAD_ALT = 2'd3} mode_t;
   typedef enum logic [1:0] {IDLE = 2'd0, COEF = 2'd1, EMIT = 2'd2} state_t;
   function automatic int w_i(input int dw, input int nb, input int l2);
      return dw + nb + 2 * l2;
   endfunction
   function automatic int chan_w(input int ch);
      return ch > 1 ? $clog2(ch) : 1;
   endfunction
endpackage

// File: rtl/intpol2_fwd_diff_acc.sv
// intpol2_fwd_diff_acc: second-order forward-difference accumulator with output rescale and saturation
module intpol2_fwd_diff_acc
   import intpol2_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N_BITS = 3,
   parameter int LOG2_L = 2,
   localparam int WI = w_i(DATA_WIDTH, N_BITS, LOG2_L)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic signed [WI-1:0]  y0,
   input  logic signed [WI-1:0]  d0,
   input  logic signed [WI-1:0]  dd0,
   output logic [DATA_WIDTH-1:0] data
);
   logic signed [WI-1:0] y, d, dd, q;
   always_ff @(posedge clk) begin
      if (rst) begin
         y <= '0;
         d <= '0;
         dd <= '0;
      end else if (load) begin
         y <= y0;
         d <= d0;
         dd <= dd0;
      end else if (step) begin
         y <= y + d;
         d <= d + dd;
      end
   end
   // y carries L^2 scaling; the arithmetic shift floors back to sample scale
   assign q = y >>> (2 * LOG2_L);
   assign data = q[WI-1:DATA_WIDTH-1] == {(WI - DATA_WIDTH + 1){q[WI-1]}} ? q[DATA_WIDTH-1:0]
               : {q[WI-1], {(DATA_WIDTH - 1){!q[WI-1]}}};
endmodule

// File: rtl/intpol2_stream_mc.sv
// intpol2_stream_mc: multichannel streaming 3-point Lagrange interpolator by L = 2**LOG2_L
// Per-channel windows feed a one-cycle coefficient stage, then L beats from the forward-difference accumulator.
module intpol2_stream_mc
   import intpol2_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N_BITS = 3,
   parameter int LOG2_L = 2,
   parameter int CHANNELS = 1,
   localparam int CW = chan_w(CHANNELS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CW-1:0]         m_chan,
   output logic                  m_valid,
   input  logic                  m_ready
);
   localparam int WI = w_i(DATA_WIDTH, N_BITS, LOG2_L);
   localparam int NC = 1 << CW;
   state_t state, state_n;
   mode_t burst_mode;
   logic signed [DATA_WIDTH-1:0] w0 [NC];
   logic signed [DATA_WIDTH-1:0] w1 [NC];
   logic signed [DATA_WIDTH-1:0] w2 [NC];
   logic [1:0] prime [NC];
   logic [CW-1:0] in_ch;
   logic [LOG2_L-1:0] k;
   logic signed [WI-1:0] a0, a1, a2, h, p1, p2, y0, d0, dd0;
   logic flush, accept, beat, primed, quad;
   assign flush = rst | clear;
   assign s_ready = state == IDLE && !flush;
   assign m_valid = state == EMIT;
   assign accept = s_valid && s_ready;
   assign beat = m_valid && m_ready;
   assign primed = prime[in_ch] == 2'd2;
   always_ff @(posedge clk) begin
      if (flush) begin
         state <= IDLE;
         k <= '0;
      end else begin
         state <= state_n;
         k <= state == COEF ? '0 : beat ? k + 1'b1 : k;
      end
   end
   always_comb begin
      state_n = state;
      state_n = state == IDLE ? (accept && primed ? COEF : IDLE)
              : state == COEF ? EMIT
              : (beat && &k) ? IDLE : EMIT;
   end
   always_ff @(posedge clk) begin
      if (flush) begin
         for (int i = 0; i < NC; i++) begin
            w0[i] <= '0;
            w1[i] <= '0;
            w2[i] <= '0;
            prime[i] <= '0;
         end
         in_ch <= '0;
         m_chan <= '0;
         burst_mode <= MODE_QUAD;
      end else if (accept) begin
         w0[in_ch] <= w1[in_ch];
         w1[in_ch] <= w2[in_ch];
         w2[in_ch] <= s_data;
         prime[in_ch] <= primed ? 2'd2 : prime[in_ch] + 2'd1;
         in_ch <= in_ch == CW'(CHANNELS - 1) ? '0 : in_ch + 1'b1;
         if (primed) begin
            m_chan <= in_ch;
            burst_mode <= mode_t'(mode);
         end
      end
   end
   // coefficients scaled so y, d, dd carry an L^2 factor and stay exact integers
   always_comb begin
      a0 = WI'(w0[m_chan]);
      a1 = WI'(w1[m_chan]);
      a2 = WI'(w2[m_chan]);
      quad = burst_mode != MODE_LIN && burst_mode != MODE_ZOH;
      h = (a2 + a0) >>> 1;
      p2 = quad ? h - a1 : '0;
      p1 = quad ? (a1 <<< 1) - a0 - h : burst_mode == MODE_LIN ? a1 - a0 : '0;
      y0 = a0 <<< (2 * LOG2_L);
      d0 = (p1 <<< LOG2_L) + p2;
      dd0 = p2 <<< 1;
   end
   intpol2_fwd_diff_acc #(
      .DATA_WIDTH(DATA_WIDTH),
      .N_BITS(N_BITS),
      .LOG2_L(LOG2_L)
   ) u_acc (
      .clk(clk),
      .rst(flush),
      .load(state == COEF),
      .step(beat),
      .y0(y0),
      .d0(d0),
      .dd0(dd0),
      .data(m_data)
   );
endmodule
